// File: rtl/wb_buffer_pkg.sv
// Shared types and defaults for the writeback buffer that sits in front of the register file.
package wb_buffer_pkg;

    localparam int unsigned REG_ADDR_W    = 3;
    localparam int unsigned WB_W_DEFAULT  = 8;
    localparam int unsigned WB_DEPTH_DEFAULT = 4;

    // One pending register-file write at the default data width
    typedef struct packed {
        logic [REG_ADDR_W-1:0]   addr;
        logic [WB_W_DEFAULT-1:0] data;
    } wb_entry_t;

    // Width of an occupancy counter that must represent 0..depth inclusive
    function automatic int unsigned wb_count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_buffer_if.sv
// Execute-side result handshake, register-file write port and decode-side forwarding lookups.
interface wb_buffer_if
    import wb_buffer_pkg::*;
#(
    parameter int unsigned W     = WB_W_DEFAULT,
    parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) ();

    logic                        res_valid;
    logic [REG_ADDR_W-1:0]       res_addr;
    logic [W-1:0]                res_data;
    logic                        res_ready;

    logic                        wb_en;
    logic                        WE;
    logic [REG_ADDR_W-1:0]       A3;
    logic [W-1:0]                data;

    logic [REG_ADDR_W-1:0]       A1;
    logic [REG_ADDR_W-1:0]       A2;
    logic                        fwd1_hit;
    logic                        fwd2_hit;
    logic [W-1:0]                fwd1_data;
    logic [W-1:0]                fwd2_data;

    logic [wb_count_w(DEPTH)-1:0] count;

    modport slave (
        input  res_valid, res_addr, res_data, wb_en, A1, A2,
        output res_ready, WE, A3, data, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
    );

    modport master (
        output res_valid, res_addr, res_data, wb_en, A1, A2,
        input  res_ready, WE, A3, data, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
    );

endinterface

// File: rtl/wb_buffer_fifo.sv
// In-order storage of pending {addr, data} writes; exposes contents oldest-first for forwarding.
module wb_fifo
    import wb_buffer_pkg::*;
#(
    parameter int unsigned W     = WB_W_DEFAULT,
    parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_push,
    input  logic                                  i_pop,
    input  logic [REG_ADDR_W-1:0]                 i_addr,
    input  logic [W-1:0]                          i_data,
    output logic [wb_count_w(DEPTH)-1:0]          o_count,
    output logic [DEPTH-1:0]                      o_age_vld,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      o_age_addr,
    output logic [DEPTH-1:0][W-1:0]               o_age_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = wb_count_w(DEPTH);

    logic [REG_ADDR_W-1:0] r_addr [DEPTH];
    logic [W-1:0]          r_data [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic                  w_push;
    logic                  w_pop;

    // Guard against overflow/underflow even if the caller misbehaves
    assign w_push = i_push && (r_count != CW'(DEPTH));
    assign w_pop  = i_pop  && (r_count != '0);

    // Payload storage carries no reset; validity is tracked by pointers and count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= i_addr;
            r_data[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_count = r_count;

    // Slot 0 is the head (oldest); higher slots are progressively younger
    always_comb begin
        o_age_vld  = '0;
        o_age_addr = '0;
        o_age_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_age_vld[i]  = CW'(i) < r_count;
            o_age_addr[i] = r_addr[r_rd_ptr + PW'(i)];
            o_age_data[i] = r_data[r_rd_ptr + PW'(i)];
        end
    end

endmodule

// File: rtl/wb_buffer.sv
// Writeback buffer: queues execute results until the register-file write port is free,
// and forwards the youngest pending value for each decode read address.
module wb_buffer
    import wb_buffer_pkg::*;
#(
    parameter int unsigned W     = WB_W_DEFAULT,
    parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    wb_buffer_if.slave bus
);

    localparam int unsigned CW = wb_count_w(DEPTH);

    logic [CW-1:0]                   w_count;
    logic [DEPTH-1:0]                w_age_vld;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] w_age_addr;
    logic [DEPTH-1:0][W-1:0]         w_age_data;

    logic                            w_occupied;
    logic                            w_ready;
    logic                            w_we;
    logic                            w_push;

    logic                            w_fwd1_hit;
    logic                            w_fwd2_hit;
    logic [W-1:0]                    w_fwd1_data;
    logic [W-1:0]                    w_fwd2_data;

    // Reset masks everything so no stale entry is visible while it is asserted
    assign w_occupied = !reset && (w_count != '0);
    assign w_ready    = reset || (w_count != CW'(DEPTH));
    assign w_we       = w_occupied && bus.wb_en;
    assign w_push     = !reset && bus.res_valid && w_ready;

    wb_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_pop      (w_we),
        .i_addr     (bus.res_addr),
        .i_data     (bus.res_data),
        .o_count    (w_count),
        .o_age_vld  (w_age_vld),
        .o_age_addr (w_age_addr),
        .o_age_data (w_age_data)
    );

    // Scan oldest to youngest so the last match wins; incoming result is not yet stored
    always_comb begin
        w_fwd1_hit  = 1'b0;
        w_fwd2_hit  = 1'b0;
        w_fwd1_data = '0;
        w_fwd2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset && w_age_vld[i] && (w_age_addr[i] == bus.A1)) begin
                w_fwd1_hit  = 1'b1;
                w_fwd1_data = w_age_data[i];
            end
            if (!reset && w_age_vld[i] && (w_age_addr[i] == bus.A2)) begin
                w_fwd2_hit  = 1'b1;
                w_fwd2_data = w_age_data[i];
            end
        end
    end

    assign bus.res_ready = w_ready;
    assign bus.WE        = w_we;
    assign bus.A3        = w_occupied ? w_age_addr[0] : '0;
    assign bus.data      = w_occupied ? w_age_data[0] : '0;
    assign bus.count     = reset ? '0 : w_count;
    assign bus.fwd1_hit  = w_fwd1_hit;
    assign bus.fwd2_hit  = w_fwd2_hit;
    assign bus.fwd1_data = w_fwd1_data;
    assign bus.fwd2_data = w_fwd2_data;

endmodule

// File: tb/tb_wb_buffer.sv
// Randomised and directed bench for wb_buffer with a queue-based reference model and write scoreboard.
module tb_wb_buffer;
    import wb_buffer_pkg::*;

    localparam int unsigned W     = WB_W_DEFAULT;
    localparam int unsigned DEPTH = WB_DEPTH_DEFAULT;

    typedef struct {
        wb_entry_t e;
        int        cyc;
    } sb_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    wb_buffer_if #(.W(W), .DEPTH(DEPTH)) bus ();

    wb_buffer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wb_entry_t model_q[$];
    sb_t       exp_q[$];
    sb_t       mon_s;
    int        n_checks = 0;
    int        n_errors = 0;
    int        cyc      = 0;
    bit        steady   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle, check combinational outputs against the model, then advance the model
    task automatic step(input bit rst, input bit v, input logic [2:0] ra, input logic [W-1:0] rd,
                        input bit wen, input logic [2:0] a1, input logic [2:0] a2);
        int           cnt;
        bit           h1, h2, push, pop;
        logic [W-1:0] d1, d2;
        wb_entry_t    ne;
        @(negedge clk);
        cyc++;
        reset         = rst;
        bus.res_valid = v;
        bus.res_addr  = ra;
        bus.res_data  = rd;
        bus.wb_en     = wen;
        bus.A1        = a1;
        bus.A2        = a2;
        if (rst) begin
            model_q.delete();
            exp_q.delete();
        end
        #1;
        cnt = model_q.size();
        h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
        for (int i = cnt - 1; i >= 0; i--) begin
            if (!h1 && model_q[i].addr == a1) begin h1 = 1'b1; d1 = model_q[i].data; end
            if (!h2 && model_q[i].addr == a2) begin h2 = 1'b1; d2 = model_q[i].data; end
        end
        chk("count",     32'(bus.count),     32'(cnt));
        chk("res_ready", 32'(bus.res_ready), 32'(cnt != DEPTH));
        chk("WE",        32'(bus.WE),        32'(cnt != 0 && wen));
        chk("A3",        32'(bus.A3),        cnt != 0 ? 32'(model_q[0].addr) : 32'd0);
        chk("data",      32'(bus.data),      cnt != 0 ? 32'(model_q[0].data) : 32'd0);
        chk("fwd1_hit",  32'(bus.fwd1_hit),  32'(h1));
        chk("fwd1_data", 32'(bus.fwd1_data), 32'(d1));
        chk("fwd2_hit",  32'(bus.fwd2_hit),  32'(h2));
        chk("fwd2_data", 32'(bus.fwd2_data), 32'(d2));
        if (!rst) begin
            push = v && (cnt < DEPTH);
            pop  = wen && (cnt > 0);
            if (pop) void'(model_q.pop_front());
            if (push) begin
                ne.addr = ra;
                ne.data = rd;
                model_q.push_back(ne);
                exp_q.push_back('{e: ne, cyc: cyc});
            end
        end
    endtask

    // Scoreboard monitor: every observed RF write must be the oldest outstanding accepted result
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (bus.WE === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write actual A3=%0h data=%0h required no write", bus.A3, bus.data);
                end else begin
                    mon_s = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.A3), 32'(mon_s.e.addr));
                    chk("wr_data", 32'(bus.data), 32'(mon_s.e.data));
                    if (steady) chk("wr_latency", 32'(cyc - mon_s.cyc), 32'd1);
                    else        chk("wr_latency_min", 32'(cyc - mon_s.cyc >= 1), 32'd1);
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 3'd0, '0, 1, 3'd0, 3'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.res_valid = 1'b0;
        bus.res_addr  = '0;
        bus.res_data  = '0;
        bus.wb_en     = 1'b0;
        bus.A1        = '0;
        bus.A2        = '0;

        step(1, 1, 3'd1, 8'hAA, 1, 3'd1, 3'd1);
        step(1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0);

        // Single result written the cycle after it is accepted
        step(0, 1, 3'd2, 8'h5A, 1, 3'd2, 3'd0);
        step(0, 0, 3'd0, 8'h00, 1, 3'd2, 3'd0);
        step(0, 0, 3'd0, 8'h00, 1, 3'd2, 3'd0);

        // Fill with write port blocked, offer a fifth, then drain in order
        for (int i = 1; i <= 4; i++) step(0, 1, 3'(i), 8'(i * 8'h11), 0, 3'(i), 3'd0);
        step(0, 1, 3'd5, 8'h55, 0, 3'd5, 3'd4);
        drain();

        // Duplicate destinations: youngest wins, unmatched address reports nothing
        step(0, 1, 3'd3, 8'h10, 0, 3'd0, 3'd0);
        step(0, 1, 3'd3, 8'h20, 0, 3'd0, 3'd0);
        step(0, 0, 3'd0, 8'h00, 0, 3'd3, 3'd5);
        chk("dup_fwd1_hit",  32'(bus.fwd1_hit),  32'd1);
        chk("dup_fwd1_data", 32'(bus.fwd1_data), 32'h20);
        chk("dup_fwd2_hit",  32'(bus.fwd2_hit),  32'd0);
        chk("dup_fwd2_data", 32'(bus.fwd2_data), 32'd0);
        // Head still forwardable while being written; same-cycle incoming not forwarded
        step(0, 1, 3'd6, 8'h66, 1, 3'd3, 3'd6);
        chk("incoming_not_fwd", 32'(bus.fwd2_hit), 32'd0);
        drain();

        // Full with offer and pop on the same edge, then accept, then wrap repeatedly
        for (int i = 0; i < 4; i++) step(0, 1, 3'(i), 8'($urandom), 0, 3'd0, 3'd1);
        step(0, 1, 3'd7, 8'h77, 1, 3'd7, 3'd0);
        step(0, 1, 3'd6, 8'h76, 0, 3'd7, 3'd6);
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < DEPTH; i++) step(0, 1, 3'($urandom), 8'($urandom), 0, 3'($urandom), 3'($urandom));
            for (int i = 0; i < DEPTH; i++) step(0, 0, 3'd0, '0, 1, 3'($urandom), 3'($urandom));
        end
        drain();

        // Reset discards pending entries
        for (int i = 0; i < 3; i++) step(0, 1, 3'(i + 1), 8'(8'hC0 + i), 0, 3'(i + 1), 3'd0);
        step(1, 1, 3'd4, 8'hEE, 1, 3'd1, 3'd2);
        for (int i = 0; i < 4; i++) step(0, 0, 3'd0, '0, 1, 3'd1, 3'd2);

        // Steady stream: one push and one pop each cycle
        step(0, 1, 3'd1, 8'h01, 1, 3'd0, 3'd0);
        steady = 1'b1;
        for (int i = 0; i < 20; i++) step(0, 1, 3'($urandom), 8'($urandom), 1, 3'($urandom), 3'($urandom));
        step(0, 0, 3'd0, '0, 1, 3'd0, 3'd0);
        steady = 1'b0;
        drain();

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70), 3'($urandom), 8'($urandom),
                 ($urandom_range(0, 99) < 50), 3'($urandom), 3'($urandom));
        end
        drain();

        @(negedge clk);
        #5;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
